sudoku_load_seq: RTL and testbench
==================================

SUDOKU_LOAD_SEQ -- requirements
Module: sudoku_load_seq

Interface
REQ-001 Clk  in  1  single clock for the block; all state changes on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset; 0 = reset.
REQ-003 Go  in  1  one-cycle request: load the stored puzzle into the solver and run it.
REQ-004 Abort  in  1  return to IDLE from any state; takes priority over Go.
REQ-005 CellAddr  out  7  puzzle memory address, 0..80, row-major (addr = 9*row + col).
REQ-006 CellData  in  4  puzzle memory data, valid one cycle after CellAddr; 0 = empty, 1..9 = given.
REQ-007 SolNext, SolEnter, SolStart  out  1 each  one-cycle pulses to the solver's Next, Enter and Start inputs.
REQ-008 SolPrev, SolSingle  out  1 each  constant 0.
REQ-009 SolValue  out  4  value presented to the solver's InputValue.
REQ-010 SolLoad, SolDisp, SolFail  in  1 each  solver state flags.
REQ-011 SolRow, SolCol  in  4 each  solver cursor.
REQ-012 Busy, Solved, Failed, Timeout, PosErr  out  1 each  status flags.
REQ-013 SolveCycles  out  24  cycle count from the SolStart pulse to the end of the solve; saturates.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RESTART, WAIT_LOAD, FETCH, LATCH, ENTER, ADVANCE, START, SOLVE, DONE and ERR.
REQ-015 All outputs SHALL be registered; SolNext, SolEnter and SolStart SHALL each be high for exactly one cycle per pulse, and never two at once.
REQ-016 IDLE: Busy=0. Go SHALL clear Solved, Failed, Timeout, PosErr and SolveCycles, set Busy=1, zero the addr/row/col counters, then go to RESTART if SolDisp|SolFail, otherwise to WAIT_LOAD.
REQ-017 RESTART SHALL pulse SolStart once, then go to WAIT_LOAD.
REQ-018 WAIT_LOAD SHALL hold until SolLoad=1, then go to FETCH.
REQ-019 FETCH SHALL drive CellAddr = addr for one cycle; LATCH SHALL capture CellData into SolValue, and values 10..15 SHALL be clamped to 0.
REQ-020 ENTER SHALL pulse SolEnter with SolValue stable.
REQ-021 In the ENTER cycle, if {SolRow,SolCol} differs from the internal {row,col}, the block SHALL go to ERR without pulsing SolEnter.
REQ-022 ADVANCE SHALL pulse SolNext and increment addr/col, wrapping col 8 to 0 and incrementing row.
- For addr=80 there SHALL be no SolNext; go straight to START.
- Otherwise return to FETCH (4 cycles per cell).
REQ-023 START SHALL pulse SolStart and clear SolveCycles; SOLVE SHALL increment SolveCycles every cycle, saturating at 24'hFFFFFF.
REQ-024 SOLVE exits:
- SolDisp=1 -> DONE with Solved=1.
- SolFail=1 -> DONE with Failed=1.
- SolveCycles reaching 24'hFFFFFF -> DONE with Timeout=1.
- If SolDisp and SolFail are both high, Solved SHALL win.
REQ-025 DONE and ERR SHALL set Busy=0 and hold the flags and SolveCycles until the next Go, which is handled as in IDLE.
REQ-026 Go while Busy=1 SHALL be ignored.
REQ-027 Abort SHALL move to IDLE next cycle, drop any pending pulse and clear Busy, and leave the flags unchanged.
REQ-028 CellAddr SHALL hold its last value outside FETCH.

Reset
REQ-029 Reset low SHALL immediately force IDLE, all pulses 0, SolValue=0, CellAddr=0, all flags 0, SolveCycles=0 and counters 0, including mid-load and mid-solve.
REQ-030 Reset release SHALL take effect on the next Clk edge; no Go is accepted in that edge's cycle.

Structure
REQ-031 State encodings, CELLS_LAST=80, GRID_LAST=8 and SOLVE_MAX=24'hFFFFFF SHALL live in a shared sudoku package used with the solver.
REQ-032 The cycle counter SHALL be one sub-module, sat_counter (width parameter, clear, enable, saturate flag).
REQ-033 Target size: 150-300 lines of RTL.

Verification
REQ-034 Solvable puzzle in the ROM, Go after reset:
- Exactly 81 SolEnter pulses, in addr order, with SolValue matching the ROM.
- 80 SolNext pulses, then one SolStart.
- Solved=1 and Busy=0 after SolDisp.
REQ-035 Conflicting givens (two 5s in row 0):
- The solver reaches FAIL.
- Failed=1, Solved=0, SolveCycles nonzero.
REQ-036 Solver left in DISP from the previous run, Go:
- One RESTART SolStart.
- Then the wait for SolLoad, then a full reload.
REQ-037 Bench model forces SolCol off by one at cell 10:
- PosErr=1 and state ERR.
- Only 10 SolEnter pulses issued.
REQ-038 Abort, then Reset, each at cell 40 and mid-solve:
- No pulse in the next cycle; Busy=0.
- Reset clears all flags; a subsequent Go performs a full reload.
REQ-039 ROM value 12 at addr 5 -> SolValue=0 on that ENTER; SolveCycles preloaded near saturation -> Timeout=1 at 24'hFFFFFF.

Source files
------------

// File: rtl/sudoku_load_seq_pkg.sv
// sudoku_load_seq_pkg: state encodings and grid limits shared by the puzzle loader and the solver.
package sudoku_load_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_RESTART, S_WAIT_LOAD, S_FETCH, S_LATCH, S_ENTER,
    S_ADVANCE, S_START, S_SOLVE, S_DONE, S_ERR
  } state_t;
  localparam logic [6:0]  CELLS_LAST = 7'd80;
  localparam logic [3:0]  GRID_LAST  = 4'd8;
  localparam logic [23:0] SOLVE_MAX  = 24'hFFFFFF;
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > 4'd9) ? 4'd0 : v;
  endfunction
endpackage

// File: rtl/sudoku_load_seq_sat_counter.sv
// sat_counter: up-counter that clears to CLR_VAL and sticks at all-ones.
module sat_counter #(
  parameter int W = 24,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign sat = &cnt_q;
  always_comb cnt_d = clr ? CLR_VAL : (en && !sat) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sudoku_load_seq.sv
// sudoku_load_seq: walks the puzzle ROM into the solver cell by cell, starts it and reports the outcome.
module sudoku_load_seq
  import sudoku_load_seq_pkg::*;
#(
  parameter logic [23:0] SOLVE_BASE = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  output logic [6:0]  cell_addr,
  input  logic [3:0]  cell_data,
  output logic        sol_next,
  output logic        sol_enter,
  output logic        sol_start,
  output logic        sol_prev,
  output logic        sol_single,
  output logic [3:0]  sol_value,
  input  logic        sol_load,
  input  logic        sol_disp,
  input  logic        sol_fail,
  input  logic [3:0]  sol_row,
  input  logic [3:0]  sol_col,
  output logic        busy,
  output logic        solved,
  output logic        failed,
  output logic        timeout,
  output logic        pos_err,
  output logic [23:0] solve_cycles
);
  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d, cell_addr_q, cell_addr_d;
  logic [3:0] row_q, row_d, col_q, col_d, sol_value_q, sol_value_d;
  logic       next_q, next_d, enter_q, enter_d, start_q, start_d, busy_q, busy_d;
  logic       solved_q, solved_d, failed_q, failed_d, timeout_q, timeout_d, pos_err_q, pos_err_d;
  logic       rdy_q, cnt_clr, cnt_en, cnt_sat;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    sol_value_d = sol_value_q;
    next_d      = 1'b0;
    enter_d     = 1'b0;
    start_d     = 1'b0;
    cnt_clr     = 1'b0;
    solved_d    = solved_q;
    failed_d    = failed_q;
    timeout_d   = timeout_q;
    pos_err_d   = pos_err_q;
    if (abort) state_d = S_IDLE;
    else case (state_q)
      S_IDLE, S_DONE, S_ERR: if (go && rdy_q) begin
        {solved_d, failed_d, timeout_d, pos_err_d} = '0;
        addr_d  = '0;
        row_d   = '0;
        col_d   = '0;
        cnt_clr = 1'b1;
        state_d = (sol_disp || sol_fail) ? S_RESTART : S_WAIT_LOAD;
      end
      S_RESTART: begin
        start_d = 1'b1;
        state_d = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: state_d = sol_load ? S_FETCH : S_WAIT_LOAD;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        sol_value_d = clamp_digit(cell_data);
        state_d     = S_ENTER;
      end
      S_ENTER: begin
        pos_err_d = {sol_row, sol_col} != {row_q, col_q};
        enter_d   = !pos_err_d;
        state_d   = pos_err_d ? S_ERR : S_ADVANCE;
      end
      S_ADVANCE: if (addr_q == CELLS_LAST) state_d = S_START;
      else begin
        next_d  = 1'b1;
        addr_d  = addr_q + 7'd1;
        col_d   = (col_q == GRID_LAST) ? 4'd0 : col_q + 4'd1;
        row_d   = (col_q == GRID_LAST) ? row_q + 4'd1 : row_q;
        state_d = S_FETCH;
      end
      S_START: begin
        start_d = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_SOLVE;
      end
      S_SOLVE: begin
        solved_d  = sol_disp;
        failed_d  = !sol_disp && sol_fail;
        timeout_d = !sol_disp && !sol_fail && cnt_sat;
        state_d   = (sol_disp || sol_fail || cnt_sat) ? S_DONE : S_SOLVE;
      end
      default: state_d = S_IDLE;
    endcase
    cell_addr_d = (state_d == S_FETCH) ? addr_d : cell_addr_q;
    busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
  end

  assign cnt_en = (state_q == S_SOLVE) && !abort;

  sat_counter #(.W(24), .CLR_VAL(SOLVE_BASE)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (solve_cycles),
    .sat  (cnt_sat)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cell_addr_q <= '0;
      sol_value_q <= '0;
      next_q      <= 1'b0;
      enter_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      solved_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      pos_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cell_addr_q <= cell_addr_d;
      sol_value_q <= sol_value_d;
      next_q      <= next_d;
      enter_q     <= enter_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      solved_q    <= solved_d;
      failed_q    <= failed_d;
      timeout_q   <= timeout_d;
      pos_err_q   <= pos_err_d;
    end

  assign cell_addr  = cell_addr_q;
  assign sol_value  = sol_value_q;
  assign sol_next   = next_q;
  assign sol_enter  = enter_q;
  assign sol_start  = start_q;
  assign sol_prev   = 1'b0;
  assign sol_single = 1'b0;
  assign busy       = busy_q;
  assign solved     = solved_q;
  assign failed     = failed_q;
  assign timeout    = timeout_q;
  assign pos_err    = pos_err_q;
endmodule

// File: tb/tb_sudoku_load_seq.sv
// tb_sudoku_load_seq: drives the loader against a behavioural solver and ROM; a second instance
// with a near-saturated count start exercises the solve timeout.
module tb_sudoku_load_seq;
  import sudoku_load_seq_pkg::*;
  localparam logic [23:0] BASE2 = SOLVE_MAX - 24'd30;
  localparam int M_LOAD = 0, M_SOLVING = 1, M_DISP = 2, M_FAIL = 3, M_RELOAD = 4;

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0;
  logic [3:0] cell_data = '0;
  logic [6:0] cell_addr, cell_addr2;
  logic [3:0] sol_value, sol_value2, sol_row, sol_col;
  logic sol_next, sol_enter, sol_start, sol_prev, sol_single;
  logic sol_next2, sol_enter2, sol_start2, sol_prev2, sol_single2;
  logic sol_load, sol_disp, sol_fail;
  logic busy, solved, failed, timeout, pos_err;
  logic busy2, solved2, failed2, timeout2, pos_err2;
  logic [23:0] solve_cycles, solve_cycles2;

  int total = 0, bad = 0;
  logic [3:0] rom [128];
  int cur = 0, mode = M_LOAD, dly = 0, cyc = 0, multi = 0;
  int enter_cnt = 0, next_cnt = 0, start_cnt = 0, first_start = -1, first_enter = -1;
  bit hold = 0, skew = 0, srst = 0, log_clr = 0;
  logic [3:0] g [81];
  logic [3:0] ent_val [81];
  int ent_pos [81];

  always #5 clk = ~clk;

  sudoku_load_seq dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .cell_addr(cell_addr), .cell_data(cell_data),
    .sol_next(sol_next), .sol_enter(sol_enter), .sol_start(sol_start), .sol_prev(sol_prev),
    .sol_single(sol_single), .sol_value(sol_value), .sol_load(sol_load), .sol_disp(sol_disp),
    .sol_fail(sol_fail), .sol_row(sol_row), .sol_col(sol_col), .busy(busy), .solved(solved),
    .failed(failed), .timeout(timeout), .pos_err(pos_err), .solve_cycles(solve_cycles)
  );

  sudoku_load_seq #(.SOLVE_BASE(BASE2)) dut2 (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .cell_addr(cell_addr2), .cell_data(cell_data),
    .sol_next(sol_next2), .sol_enter(sol_enter2), .sol_start(sol_start2), .sol_prev(sol_prev2),
    .sol_single(sol_single2), .sol_value(sol_value2), .sol_load(sol_load), .sol_disp(sol_disp),
    .sol_fail(sol_fail), .sol_row(sol_row), .sol_col(sol_col), .busy(busy2), .solved(solved2),
    .failed(failed2), .timeout(timeout2), .pos_err(pos_err2), .solve_cycles(solve_cycles2)
  );

  always @(posedge clk) cell_data <= rom[cell_addr];

  assign sol_load = (mode == M_LOAD);
  assign sol_disp = (mode == M_DISP);
  assign sol_fail = (mode == M_FAIL);
  assign sol_row  = 4'(cur / 9);
  assign sol_col  = 4'(cur % 9 + ((skew && cur == 10) ? 1 : 0));

  function automatic bit row_conflict();
    for (int r = 0; r < 9; r++)
      for (int a = 0; a < 9; a++)
        for (int b = a + 1; b < 9; b++)
          if (g[9*r+a] != 0 && g[9*r+a] == g[9*r+b]) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural solver: LOAD takes entries at its cursor, Start solves after a delay,
  // Start from DISP/FAIL returns to LOAD after a short reload.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (int'(sol_next) + int'(sol_enter) + int'(sol_start) > 1) multi <= multi + 1;
    if (log_clr) begin
      enter_cnt <= 0; next_cnt <= 0; start_cnt <= 0; first_start <= -1; first_enter <= -1;
    end else begin
      if (sol_enter) begin
        if (enter_cnt < 81) begin ent_val[enter_cnt] <= sol_value; ent_pos[enter_cnt] <= cur; end
        enter_cnt <= enter_cnt + 1;
        if (first_enter < 0) first_enter <= cyc;
      end
      if (sol_next) next_cnt <= next_cnt + 1;
      if (sol_start) begin
        start_cnt <= start_cnt + 1;
        if (first_start < 0) first_start <= cyc;
      end
    end
    if (srst) begin
      mode <= M_LOAD; cur <= 0; dly <= 0;
      for (int i = 0; i < 81; i++) g[i] <= '0;
    end else begin
      if (sol_enter && mode == M_LOAD && cur < 81) g[cur] <= sol_value;
      if (sol_next) cur <= cur + 1;
      case (mode)
        M_LOAD: if (sol_start) begin mode <= M_SOLVING; dly <= 5; end
        M_SOLVING: if (dly > 0) dly <= dly - 1;
                   else if (!hold) mode <= row_conflict() ? M_FAIL : M_DISP;
        M_DISP, M_FAIL: if (sol_start) begin mode <= M_RELOAD; dly <= 3; end
        default: if (dly > 0) dly <= dly - 1;
                 else begin
                   mode <= M_LOAD; cur <= 0;
                   for (int i = 0; i < 81; i++) g[i] <= '0;
                 end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input bit clash);
    for (int i = 0; i < 128; i++) rom[i] = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        rom[9*r+c] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'(((r*3 + r/3 + c) % 9) + 1);
    rom[5] = 4'd12;
    if (clash) begin rom[0] = 4'd5; rom[1] = 4'd5; end
  endtask

  task automatic prep(input bit solver_reset);
    log_clr = 1; srst = solver_reset;
    @(negedge clk);
    log_clr = 0; srst = 0;
  endtask

  task automatic pulse_go();
    go = 1;
    @(negedge clk);
    go = 0;
  endtask

  task automatic pulse_abort();
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic wait_idle2(input string tag);
    int n = 0;
    while (busy2 && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 32'(busy2), 0);
  endtask

  task automatic wait_enters(input int k, input string tag);
    int n = 0;
    while (enter_cnt < k && n < 1000) begin @(negedge clk); n++; end
    chk(tag, 32'(enter_cnt >= k), 1);
  endtask

  initial begin
    fill_rom(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(cell_addr), 0);
    chk("rst_cycles", 32'(solve_cycles), 0);
    chk("rst_pulses", 32'({sol_next, sol_enter, sol_start}), 0);
    chk("const_prev_single", 32'({sol_prev, sol_single}), 0);
    rst_n = 1; go = 1;
    @(negedge clk);
    go = 0;
    chk("go_at_release_ignored", 32'(busy), 0);

    prep(1'b1);
    pulse_go();
    chk("busy_after_go", 32'(busy), 1);
    repeat (20) @(negedge clk);
    pulse_go();
    wait_idle("load1_done");
    chk("load1_enters", 32'(enter_cnt), 81);
    chk("load1_nexts", 32'(next_cnt), 80);
    chk("load1_starts", 32'(start_cnt), 1);
    for (int i = 0; i < 81; i++) begin
      logic [3:0] exp_v;
      exp_v = (rom[i] > 4'd9) ? 4'd0 : rom[i];
      chk($sformatf("load1_val%0d", i), 32'(ent_val[i]), 32'(exp_v));
      chk($sformatf("load1_pos%0d", i), 32'(ent_pos[i]), 32'(i));
    end
    chk("load1_solved", 32'({solved, failed, timeout, pos_err}), 32'b1000);
    chk("load1_cycles_nz", 32'(solve_cycles != 0), 1);
    chk("addr_hold", 32'(cell_addr), 80);

    prep(1'b0);
    pulse_go();
    wait_idle("restart_done");
    chk("restart_starts", 32'(start_cnt), 2);
    chk("restart_before_load", 32'(first_start >= 0 && first_start < first_enter), 1);
    chk("restart_enters", 32'(enter_cnt), 81);
    chk("restart_nexts", 32'(next_cnt), 80);
    chk("restart_solved", 32'(solved), 1);

    fill_rom(1'b1);
    prep(1'b0);
    pulse_go();
    wait_idle("clash_done");
    chk("clash_flags", 32'({solved, failed, timeout, pos_err}), 32'b0100);
    chk("clash_cycles_nz", 32'(solve_cycles != 0), 1);
    chk("clash_busy2", 32'({busy2, failed2}), 32'b01);

    fill_rom(1'b0);
    skew = 1;
    prep(1'b0);
    pulse_go();
    wait_idle("skew_done");
    chk("skew_flags", 32'({solved, failed, timeout, pos_err}), 32'b0001);
    chk("skew_enters", 32'(enter_cnt), 10);
    chk("skew_state", 32'(dut.state_q), 32'(S_ERR));
    skew = 0;

    prep(1'b1);
    pulse_go();
    wait_enters(40, "abort40_reach");
    pulse_abort();
    chk("abort40_busy", 32'(busy), 0);
    chk("abort40_pulses", 32'({sol_next, sol_enter, sol_start}), 0);
    chk("abort40_state", 32'(dut.state_q), 32'(S_IDLE));
    repeat (3) @(negedge clk);
    chk("abort40_enters", 32'(enter_cnt), 40);
    go = 1; abort = 1;
    @(negedge clk);
    go = 0; abort = 0;
    chk("abort_over_go", 32'(busy), 0);

    prep(1'b1);
    pulse_go();
    wait_enters(40, "rst40_reach");
    rst_n = 0;
    #1;
    chk("rst40_busy", 32'(busy), 0);
    chk("rst40_addr_val", 32'({cell_addr, sol_value}), 0);
    chk("rst40_pulses", 32'({sol_next, sol_enter, sol_start}), 0);
    @(negedge clk);
    rst_n = 1;

    hold = 1;
    prep(1'b1);
    pulse_go();
    wait_idle2("timeout_done");
    chk("timeout_flags", 32'({solved2, failed2, timeout2, pos_err2}), 32'b0010);
    chk("timeout_cycles", 32'(solve_cycles2), 32'(SOLVE_MAX));
    chk("midsolve_busy", 32'({busy, timeout}), 32'b10);
    pulse_abort();
    chk("abortsolve_busy", 32'(busy), 0);
    chk("abortsolve_pulses", 32'({sol_next, sol_enter, sol_start}), 0);
    chk("abort_keeps_flags", 32'(timeout2), 1);

    prep(1'b1);
    pulse_go();
    wait_idle2("timeout2_done");
    chk("timeout2_set", 32'(timeout2), 1);
    rst_n = 0;
    #1;
    chk("rstsolve_flags2", 32'({solved2, failed2, timeout2, pos_err2}), 0);
    chk("rstsolve_cycles", 32'({solve_cycles, solve_cycles2} != 0), 0);
    chk("rstsolve_busy", 32'({busy, busy2}), 0);
    @(negedge clk);
    rst_n = 1;
    hold = 0;

    prep(1'b1);
    pulse_go();
    wait_idle("final_done");
    chk("final_enters", 32'(enter_cnt), 81);
    chk("final_nexts", 32'(next_cnt), 80);
    chk("final_starts", 32'(start_cnt), 1);
    chk("final_solved", 32'(solved), 1);
    chk("no_overlap_pulses", 32'(multi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
